fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the datapath's EX-stage forwarding logic. Merges operand forwarding with load-use hazard detection and a configurable-length stall sequencer.
- Sits beside the ID/EX pipeline register. Drives ALU operand mux selects, PC/IF-ID hold and the ID/EX bubble.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: number of bubble cycles per load-use hazard. Legal range is 1 to 7.
- CNT_W, 16: width of the StallCount performance counter.

Ports:
- Clk  in  1  clock, rising-edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- RS_ID  in  REG_AW  rs of the instruction in ID.
- RT_ID  in  REG_AW  rt of the instruction in ID.
- UsesRT_ID  in  1  ID instruction reads rt.
- RS_EX  in  REG_AW  rs of the instruction in EX.
- RT_EX  in  REG_AW  rt of the instruction in EX.
- RD_EX  in  REG_AW  destination of the instruction in EX.
- RegWrite_EX  in  1  EX instruction writes a register.
- MemRead_EX  in  1  EX instruction is a load.
- RD_MEM  in  REG_AW  destination in MEM.
- RegWrite_MEM  in  1  MEM instruction writes a register.
- RD_WB  in  REG_AW  destination in WB.
- RegWrite_WB  in  1  WB instruction writes a register.
- Freeze  in  1  external pipeline freeze (e.g. memory wait).
- ClrCount  in  1  synchronous clear of StallCount.
- ForwardA  out  2  ALU A select: 00 register file, 10 MEM, 01 WB.
- ForwardB  out  2  ALU B select, same encoding as ForwardA.
- Stall  out  1  hold PC and IF/ID.
- Flush_EX  out  1  insert bubble into ID/EX.
- StallCount  out  CNT_W  number of cycles with Stall high, saturating.

Behaviour:
- Reset: Clk, one clock domain; Rst_n asynchronous, active-low.
  - While Rst_n=0: FSM=IDLE, bubble counter=0, StallCount=0.
  - Stall, Flush_EX, ForwardA and ForwardB are forced to 0 (combinational gate).
- Forwarding: combinational, zero latency.
  - ForwardA=10 if RegWrite_MEM && RD_MEM!=0 && RD_MEM==RS_EX.
  - Otherwise ForwardA=01 if RegWrite_WB && RD_WB!=0 && RD_WB==RS_EX.
  - Otherwise ForwardA=00.
  - ForwardB uses the same rules against RT_EX, evaluated independently of ForwardA.
  - MEM always has priority over WB. Register 0 is never forwarded.
- Hazard detect (combinational): Hz = MemRead_EX && RegWrite_EX && RD_EX!=0 && (RD_EX==RS_ID || (UsesRT_ID && RD_EX==RT_ID)).
- FSM states: IDLE, STALL. Counter width is 3 bits.
  - IDLE: Stall = Hz. If Hz && LOAD_LAT>1 && !Freeze, load counter with LOAD_LAT-1 and go to STALL.
  - STALL: Stall=1. If !Freeze, decrement the counter. When the counter is 1 and !Freeze, go to IDLE.
  - Freeze=1: state and counter hold. Stall keeps its value by the rules above.
- Stall timing:
  - LOAD_LAT=1: the FSM never leaves IDLE. Exactly one bubble per hazard.
  - Total Stall-high cycles per hazard = LOAD_LAT, plus any Freeze cycles that occur inside the sequence.
- Flush_EX = Stall in every cycle.
- Back-to-back loads: a new Hz seen in IDLE on the cycle after returning from STALL starts a new sequence. No cycle is lost.
- StallCount:
  - Increments on each clock edge where Stall=1, and sticks at 2^CNT_W-1.
  - ClrCount=1 sets it to 0 on that edge and takes priority over increment.
- Reset mid-sequence: immediate return to IDLE. Outputs drop to 0 asynchronously.

Test Plan:
- Forward priority: RD_MEM=RD_WB=RS_EX=5, both RegWrite=1 -> ForwardA=10. Then RegWrite_MEM=0 -> ForwardA=01.
- Zero register: RD_MEM=0=RS_EX=RT_EX, RegWrite_MEM=1 -> ForwardA=ForwardB=00. Separately, RD_WB=7=RT_EX with RS_EX≠7 -> ForwardB=01, ForwardA=00.
- Load-use, LOAD_LAT=1: MemRead_EX=1, RD_EX=3=RT_ID, UsesRT_ID=1 -> Stall=Flush_EX=1 for 1 cycle, StallCount 0→1. Same with UsesRT_ID=0 -> no stall.
- Load-use, LOAD_LAT=3, Freeze=1 on the 2nd stall cycle -> Stall high for 4 consecutive cycles, then 0. StallCount=4.
- Async reset: assert Rst_n=0 in the 2nd cycle of a LOAD_LAT=3 stall -> Stall=0 immediately, StallCount=0. Release -> IDLE, no residual stall.
- Saturation/clear: CNT_W=4 with 20 stall cycles -> StallCount holds 15. ClrCount and Stall both high -> 0 on that edge, 1 on the next stall edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Purpose : EX-stage operand forwarding, load-use hazard detection and stall sequencing.
// Latency : forwarding/hazard/stall are combinational (0 cycles); StallCount updates on the edge.
// Backpr. : Stall/Flush_EX hold PC, IF/ID and bubble ID/EX; Freeze pauses the stall sequence.
//
// Ports:
//   Clk, Rst_n                 clock (rising edge), async active-low reset
//   RS_ID/RT_ID/UsesRT_ID      source operands of the instruction in ID
//   RS_EX/RT_EX/RD_EX          operands/destination of the instruction in EX
//   RegWrite_EX, MemRead_EX    EX writes a register / EX is a load
//   RD_MEM/RegWrite_MEM        MEM-stage producer
//   RD_WB/RegWrite_WB          WB-stage producer
//   Freeze                     external pipeline freeze
//   ClrCount                   synchronous clear of StallCount
//   ForwardA/ForwardB          ALU operand selects: 00 regfile, 10 MEM, 01 WB
//   Stall, Flush_EX            hold front end / insert bubble into ID/EX
//   StallCount                 saturating count of Stall-high cycles
//
// LOAD_LAT must lie in 1..7: the bubble sequencer counter is 3 bits wide.

module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] RS_ID,
  input  logic [REG_AW-1:0] RT_ID,
  input  logic              UsesRT_ID,
  input  logic [REG_AW-1:0] RS_EX,
  input  logic [REG_AW-1:0] RT_EX,
  input  logic [REG_AW-1:0] RD_EX,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] RD_MEM,
  input  logic              RegWrite_MEM,
  input  logic [REG_AW-1:0] RD_WB,
  input  logic              RegWrite_WB,
  input  logic              Freeze,
  input  logic              ClrCount,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              Stall,
  output logic              Flush_EX,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0]       FWD_RF  = 2'b00;
  localparam logic [1:0]       FWD_MEM = 2'b10;
  localparam logic [1:0]       FWD_WB  = 2'b01;

  // The hazard cycle itself is the first bubble; the sequencer covers the rest.
  localparam logic [2:0]       SEQ_EXTRA = 3'(LOAD_LAT - 1);
  localparam bit               MULTI_BUBBLE = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Forwarding: MEM is newer than WB, so it wins. r0 is hard-wired zero and is
  // never forwarded even if some stage claims to write it.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd_mem,
    input logic              rw_mem,
    input logic [REG_AW-1:0] rd_wb,
    input logic              rw_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rw_mem && (rd_mem != '0) && (rd_mem == src)) begin
      sel = FWD_MEM;
    end else if (rw_wb && (rd_wb != '0) && (rd_wb == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_comb begin
    fwd_a = fwd_sel(RS_EX, RD_MEM, RegWrite_MEM, RD_WB, RegWrite_WB);
    fwd_b = fwd_sel(RT_EX, RD_MEM, RegWrite_MEM, RD_WB, RegWrite_WB);
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by the ID
  // instruction. rt only matters when the ID instruction actually reads it.
  // ---------------------------------------------------------------------------
  logic hz;

  always_comb begin
    hz = MemRead_EX && RegWrite_EX && (RD_EX != '0) &&
         ((RD_EX == RS_ID) || (UsesRT_ID && (RD_EX == RT_ID)));
  end

  // ---------------------------------------------------------------------------
  // Stall sequencer. cnt_q holds the number of STALL cycles still to issue.
  // Freeze holds state and counter; Stall keeps following the state rules.
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       stall_raw;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        stall_raw = hz;
        if (hz && MULTI_BUBBLE && !Freeze) begin
          cnt_d   = SEQ_EXTRA;
          state_d = STALL;
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        if (!Freeze) begin
          cnt_d = cnt_q - 3'd1;
          // Last extra bubble: back to IDLE so a following load-use hazard
          // is picked up on the very next cycle.
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle performance counter: saturating, clear beats increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
    end else if (ClrCount) begin
      StallCount <= '0;
    end else if (stall_raw && (StallCount != CNT_MAX)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are gated by reset so the pipeline sees no stall or forward
  // while reset is asserted, independent of the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    ForwardA = Rst_n ? fwd_a : FWD_RF;
    ForwardB = Rst_n ? fwd_b : FWD_RF;
    Stall    = Rst_n & stall_raw;
    Flush_EX = Rst_n & stall_raw;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose : directed self-checking bench for fwd_hazard_unit (three parameter sets).
// Latency : combinational outputs checked 1 ns after inputs settle; counters after the edge.
// Backpr. : n/a (bench drives Freeze directly).

module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic       uses_rt_id, rw_ex, rw_mem, rw_wb, freeze, clr_c;
  logic       mr_a, mr_b, mr_c;

  logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
  logic        st_a, fl_a, st_b, fl_b, st_c, fl_c;
  logic [15:0] sc_a, sc_b;
  logic [3:0]  sc_c;

  // ua: LOAD_LAT=1; ub: LOAD_LAT=3; uc: LOAD_LAT=1 with a 4-bit counter.
  // Only the instance whose MemRead_EX is raised sees a hazard.
  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) ua (
    .Clk(clk), .Rst_n(rst_n), .RS_ID(rs_id), .RT_ID(rt_id), .UsesRT_ID(uses_rt_id),
    .RS_EX(rs_ex), .RT_EX(rt_ex), .RD_EX(rd_ex), .RegWrite_EX(rw_ex), .MemRead_EX(mr_a),
    .RD_MEM(rd_mem), .RegWrite_MEM(rw_mem), .RD_WB(rd_wb), .RegWrite_WB(rw_wb),
    .Freeze(freeze), .ClrCount(1'b0), .ForwardA(fa_a), .ForwardB(fb_a),
    .Stall(st_a), .Flush_EX(fl_a), .StallCount(sc_a));

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) ub (
    .Clk(clk), .Rst_n(rst_n), .RS_ID(rs_id), .RT_ID(rt_id), .UsesRT_ID(uses_rt_id),
    .RS_EX(rs_ex), .RT_EX(rt_ex), .RD_EX(rd_ex), .RegWrite_EX(rw_ex), .MemRead_EX(mr_b),
    .RD_MEM(rd_mem), .RegWrite_MEM(rw_mem), .RD_WB(rd_wb), .RegWrite_WB(rw_wb),
    .Freeze(freeze), .ClrCount(1'b0), .ForwardA(fa_b), .ForwardB(fb_b),
    .Stall(st_b), .Flush_EX(fl_b), .StallCount(sc_b));

  fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) uc (
    .Clk(clk), .Rst_n(rst_n), .RS_ID(rs_id), .RT_ID(rt_id), .UsesRT_ID(uses_rt_id),
    .RS_EX(rs_ex), .RT_EX(rt_ex), .RD_EX(rd_ex), .RegWrite_EX(rw_ex), .MemRead_EX(mr_c),
    .RD_MEM(rd_mem), .RegWrite_MEM(rw_mem), .RD_WB(rd_wb), .RegWrite_WB(rw_wb),
    .Freeze(freeze), .ClrCount(clr_c), .ForwardA(fa_c), .ForwardB(fb_c),
    .Stall(st_c), .Flush_EX(fl_c), .StallCount(sc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic sb_push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=<none>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    uses_rt_id = 0; rw_ex = 0; rw_mem = 0; rw_wb = 0; freeze = 0; clr_c = 0;
    mr_a = 0; mr_b = 0; mr_c = 0;
  endtask

  // Load in EX writing r3, ID instruction reads r3 through rt.
  task automatic load_use_rt();
    rd_ex = 5'd3; rt_id = 5'd3; rs_id = 5'd1; uses_rt_id = 1'b1; rw_ex = 1'b1;
  endtask

  initial begin
    // ---------------- reset: outputs gated even with active patterns -------
    clear_inputs();
    rst_n = 1'b0;
    rd_mem = 5'd5; rs_ex = 5'd5; rw_mem = 1'b1;
    load_use_rt();
    mr_b = 1'b1;
    #2;
    sb_push("rst_fwd_a", 0);   sb_check(32'(fa_a));
    sb_push("rst_stall", 0);   sb_check(32'(st_b));
    sb_push("rst_flush", 0);   sb_check(32'(fl_b));
    tick(); tick();
    sb_push("rst_cnt", 0);     sb_check(32'(sc_b));
    sb_push("rst_stall2", 0);  sb_check(32'(st_b));
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // ---------------- forwarding ------------------------------------------
    rd_mem = 5'd5; rd_wb = 5'd5; rs_ex = 5'd5; rw_mem = 1'b1; rw_wb = 1'b1;
    sb_push("fwd_mem_prio", 2); #1 sb_check(32'(fa_a));
    tick();
    rw_mem = 1'b0;
    sb_push("fwd_wb", 1);       #1 sb_check(32'(fa_a));
    tick();
    clear_inputs();
    rw_mem = 1'b1; rw_wb = 1'b1;
    sb_push("fwd_r0_a", 0);
    sb_push("fwd_r0_b", 0);
    #1 sb_check(32'(fa_a)); sb_check(32'(fb_a));
    tick();
    clear_inputs();
    rd_wb = 5'd7; rt_ex = 5'd7; rs_ex = 5'd2; rw_wb = 1'b1;
    sb_push("fwd_wb_b", 1);
    sb_push("fwd_wb_a_none", 0);
    #1 sb_check(32'(fb_a)); sb_check(32'(fa_a));
    tick();
    clear_inputs();
    rd_mem = 5'd4; rs_ex = 5'd4; rw_mem = 1'b1; rd_wb = 5'd9; rt_ex = 5'd9; rw_wb = 1'b1;
    sb_push("fwd_indep_a", 2);
    sb_push("fwd_indep_b", 1);
    #1 sb_check(32'(fa_b)); sb_check(32'(fb_b));
    tick();

    // ---------------- load-use, LOAD_LAT=1 --------------------------------
    clear_inputs();
    load_use_rt(); mr_a = 1'b1;
    sb_push("ll1_stall", 1);
    sb_push("ll1_flush", 1);
    sb_push("ll1_cnt0", 0);
    #1 sb_check(32'(st_a)); sb_check(32'(fl_a)); sb_check(32'(sc_a));
    tick();
    clear_inputs();
    sb_push("ll1_cnt1", 1);
    sb_push("ll1_release", 0);
    #1 sb_check(32'(sc_a)); sb_check(32'(st_a));
    tick();
    load_use_rt(); uses_rt_id = 1'b0; mr_a = 1'b1;
    sb_push("ll1_no_rt_use", 0); #1 sb_check(32'(st_a));
    tick();
    rs_id = 5'd3;
    sb_push("ll1_rs_match", 1);  #1 sb_check(32'(st_a));
    tick();
    clear_inputs();
    sb_push("ll1_cnt2", 2);      #1 sb_check(32'(sc_a));
    tick();

    // ---------------- load-use, LOAD_LAT=3, freeze on 2nd cycle -----------
    load_use_rt(); mr_b = 1'b1;
    sb_push("ll3_c1", 1); #1 sb_check(32'(st_b));
    tick();
    mr_b = 1'b0; freeze = 1'b1;
    sb_push("ll3_c2_frz", 1); #1 sb_check(32'(st_b));
    tick();
    freeze = 1'b0;
    sb_push("ll3_c3", 1); #1 sb_check(32'(st_b));
    tick();
    sb_push("ll3_c4", 1); #1 sb_check(32'(fl_b));
    tick();
    sb_push("ll3_done", 0);
    sb_push("ll3_cnt4", 4);
    #1 sb_check(32'(st_b)); sb_check(32'(sc_b));

    // ---------------- back-to-back loads, LOAD_LAT=3 ----------------------
    for (int i = 0; i < 6; i++) begin
      tick();
      mr_b = (i == 0 || i == 3);
      sb_push("b2b_stall", 1); #1 sb_check(32'(st_b));
    end
    tick();
    mr_b = 1'b0;
    sb_push("b2b_idle", 0);
    sb_push("b2b_cnt10", 10);
    #1 sb_check(32'(st_b)); sb_check(32'(sc_b));
    tick();

    // ---------------- async reset mid-sequence ----------------------------
    mr_b = 1'b1;
    sb_push("ar_c1", 1); #1 sb_check(32'(st_b));
    tick();
    mr_b = 1'b0;
    sb_push("ar_c2", 1); #1 sb_check(32'(st_b));
    #1 rst_n = 1'b0;
    sb_push("ar_stall0", 0);
    sb_push("ar_flush0", 0);
    sb_push("ar_cnt0", 0);
    #1 sb_check(32'(st_b)); sb_check(32'(fl_b)); sb_check(32'(sc_b));
    tick(); tick();
    rst_n = 1'b1;
    sb_push("ar_rel_stall", 0); #1 sb_check(32'(st_b));
    tick();
    sb_push("ar_no_resid", 0);
    sb_push("ar_cnt_stay0", 0);
    #1 sb_check(32'(st_b)); sb_check(32'(sc_b));
    tick();

    // ---------------- saturation and clear, CNT_W=4 -----------------------
    clear_inputs();
    load_use_rt(); mr_c = 1'b1;
    sb_push("sat_stall", 1); #1 sb_check(32'(st_c));
    for (int i = 0; i < 15; i++) tick();
    sb_push("sat_reach15", 15); sb_check(32'(sc_c));
    for (int i = 0; i < 5; i++) tick();
    sb_push("sat_hold15", 15);  sb_check(32'(sc_c));
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    sb_push("clr_prio", 0);     sb_check(32'(sc_c));
    tick();
    sb_push("clr_then_inc", 1); sb_check(32'(sc_c));
    clear_inputs();
    tick();

    // ---------------- scoreboard drained ----------------------------------
    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
